// File: rtl/cnt_mod_pkg.sv
// cnt_defs: direction encoding and parameter-legality check shared by all counter variants.
// CNT_PARAM_CHECK(W, M, R) expands to a generate-time $error in the including module.
package cnt_defs;

    typedef enum logic {
        CNT_DIR_UP   = 1'b0,
        CNT_DIR_DOWN = 1'b1
    } cnt_dir_e;

    function automatic bit cnt_params_ok(
        input int unsigned     width,
        input longint unsigned modv,
        input longint unsigned rst_val
    );
        return (width >= 1) && (modv >= 2) && (modv <= (64'd1 << width)) && (rst_val < modv);
    endfunction

endpackage

`ifndef CNT_PARAM_CHECK
`define CNT_PARAM_CHECK(W, M, R) \
    if (!cnt_defs::cnt_params_ok(W, M, R)) begin : g_param_check \
        $error("cnt: illegal parameters, need 2 <= MOD <= 2**WIDTH and RST_VAL < MOD"); \
    end
`endif

// File: rtl/cnt_mod_tc_det.sv
// cnt_tc_det: combinational terminal-value detector shared by next-state logic and outputs.
module cnt_tc_det
    import cnt_defs::*;
#(
    parameter int WIDTH = 3,
    parameter int MOD   = 3
) (
    input  logic [WIDTH-1:0] cnt,
    input  cnt_dir_e         dir,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    always_comb begin
        at_max = (cnt == MAX_V);
        at_min = (cnt == '0);
        tc     = (dir == CNT_DIR_DOWN) ? at_min : at_max;
    end

endmodule

// File: rtl/cnt_mod.sv
// cnt_mod: modulo-MOD counter with clear, load (clamped), enable, tc/co cascade and wrap pulse.
// Define CNT_DOWN_EN to add the dir port and down-count mode; default build is up-only.
module cnt_mod
    import cnt_defs::*;
#(
    parameter int WIDTH   = 3,
    parameter int MOD     = 3,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef CNT_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             co,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

    `CNT_PARAM_CHECK(WIDTH, MOD, RST_VAL)

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    cnt_dir_e         dir_w;
    logic             at_max;
    logic             tc_w;
    logic             in_range;
    logic             load_ok;

`ifdef CNT_DOWN_EN
    logic at_min;
    assign dir_w = cnt_dir_e'(dir);
`else
    logic at_min_unused;
    assign dir_w = CNT_DIR_UP;
`endif

    cnt_tc_det #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_tc_det (
        .cnt    (cnt_q),
        .dir    (dir_w),
        .at_max (at_max),
`ifdef CNT_DOWN_EN
        .at_min (at_min),
`else
        .at_min (at_min_unused),
`endif
        .tc     (tc_w)
    );

    // Compare one bit wider so MOD = 2**WIDTH needs no special case.
    assign in_range = ({1'b0, cnt_q} < MOD_X);
    assign load_ok  = ({1'b0, load_val} < MOD_X);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_ok ? load_val : MAX_V;
        end else if (en) begin
`ifdef CNT_DOWN_EN
            if (dir_w == CNT_DIR_DOWN) begin
                if (at_min) begin
                    cnt_d  = MAX_V;
                    wrap_d = 1'b1;
                end else if (!in_range) begin
                    cnt_d = MAX_V;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else
`endif
            begin
                if (at_max) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else if (!in_range) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= RST_V;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign tc   = tc_w;
    assign co   = en & tc_w & ~clr & ~load;

endmodule
